// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the CPU/UART data-RAM port arbiter.
// Arbiter states and read-return owner tags.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_SHARED  = 2'd0,
    ARB_LOCKED  = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_e;

  localparam logic OWN_CPU  = 1'b0;
  localparam logic OWN_UART = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous data RAM between the CPU MEM-stage port and the UART loader.
// CPU wins contested cycles until the starvation guard forces UART through; UART may lock the RAM.
//
// state       | meaning
// ARB_SHARED  | normal CPU-priority arbitration with starvation guard
// ARB_LOCKED  | UART owns the RAM exclusively, CPU stalls
// ARB_RELEASE | single turnaround cycle, no grants, last UART read returns
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_gnt,
  output logic              o_cpu_stall,
  output logic              o_cpu_rvalid,
  output logic [DATA_W-1:0] o_cpu_rdata,
  input  logic              i_uart_req,
  input  logic              i_uart_we,
  input  logic [ADDR_W-1:0] i_uart_addr,
  input  logic [DATA_W-1:0] i_uart_wdata,
  output logic              o_uart_gnt,
  output logic              o_uart_rvalid,
  output logic [DATA_W-1:0] o_uart_rdata,
  input  logic              i_uart_lock,
  output logic              o_locked,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  arb_state_e        r_state;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic              r_pend;
  logic              r_owner;
  logic              r_locked;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_uart_rdata;

  logic              w_cpu_gnt;
  logic              w_uart_gnt;
  logic              w_contested;
  logic              w_cpu_rvalid;
  logic              w_uart_rvalid;

  assign w_contested = i_cpu_req & i_uart_req;

  always_comb begin
    w_cpu_gnt  = 1'b0;
    w_uart_gnt = 1'b0;
    if (i_reset) begin
      case (r_state)
        ARB_SHARED: begin
          if (w_contested) begin
            if (r_starve_cnt == STARVE_LIM) w_uart_gnt = 1'b1;
            else                            w_cpu_gnt  = 1'b1;
          end else begin
            w_cpu_gnt  = i_cpu_req;
            w_uart_gnt = i_uart_req;
          end
        end
        ARB_LOCKED: w_uart_gnt = i_uart_req;
        default: begin
          w_cpu_gnt  = 1'b0;
          w_uart_gnt = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    o_ram_we    = 1'b0;
    o_ram_addr  = '0;
    o_ram_wdata = '0;
    if (w_cpu_gnt) begin
      o_ram_we    = i_cpu_we;
      o_ram_addr  = i_cpu_addr;
      o_ram_wdata = i_cpu_wdata;
    end else if (w_uart_gnt) begin
      o_ram_we    = i_uart_we;
      o_ram_addr  = i_uart_addr;
      o_ram_wdata = i_uart_wdata;
    end
  end

  // Return path is gated by reset so a read in flight when reset hits is dropped.
  assign w_cpu_rvalid  = i_reset & r_pend & (r_owner == OWN_CPU);
  assign w_uart_rvalid = i_reset & r_pend & (r_owner == OWN_UART);

  assign o_cpu_gnt     = w_cpu_gnt;
  assign o_uart_gnt    = w_uart_gnt;
  assign o_cpu_stall   = i_cpu_req & ~w_cpu_gnt;
  assign o_ram_en      = w_cpu_gnt | w_uart_gnt;
  assign o_cpu_rvalid  = w_cpu_rvalid;
  assign o_uart_rvalid = w_uart_rvalid;
  assign o_cpu_rdata   = w_cpu_rvalid  ? i_ram_rdata : r_cpu_rdata;
  assign o_uart_rdata  = w_uart_rvalid ? i_ram_rdata : r_uart_rdata;
  assign o_locked      = r_locked;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= ARB_SHARED;
      r_starve_cnt <= '0;
      r_pend       <= 1'b0;
      r_owner      <= OWN_CPU;
      r_locked     <= 1'b0;
      r_cpu_rdata  <= '0;
      r_uart_rdata <= '0;
    end else begin
      r_pend  <= (w_cpu_gnt & ~i_cpu_we) | (w_uart_gnt & ~i_uart_we);
      r_owner <= w_uart_gnt ? OWN_UART : OWN_CPU;

      if (w_cpu_rvalid)  r_cpu_rdata  <= i_ram_rdata;
      if (w_uart_rvalid) r_uart_rdata <= i_ram_rdata;

      if (r_state == ARB_RELEASE || w_uart_gnt) begin
        r_starve_cnt <= '0;
      end else if (r_state == ARB_SHARED && w_contested && w_cpu_gnt &&
                   r_starve_cnt != STARVE_LIM) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end

      case (r_state)
        ARB_SHARED: begin
          if (i_uart_lock) begin
            r_state  <= ARB_LOCKED;
            r_locked <= 1'b1;
          end
        end
        ARB_LOCKED: begin
          if (!i_uart_lock) begin
            r_state  <= ARB_RELEASE;
            r_locked <= 1'b0;
          end
        end
        default: begin
          r_state  <= ARB_SHARED;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus random stimulus for mem_port_arbiter, checked against a behavioural model
// that tracks mode, starvation count, pending reads and a shadow copy of RAM contents.
module tb_mem_port_arbiter;

  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          uart_req, uart_we, uart_gnt, uart_rvalid, uart_lock, locked;
  logic [AW-1:0] uart_addr;
  logic [DW-1:0] uart_wdata, uart_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_gnt(cpu_gnt), .o_cpu_stall(cpu_stall), .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata),
    .i_uart_req(uart_req), .i_uart_we(uart_we), .i_uart_addr(uart_addr), .i_uart_wdata(uart_wdata),
    .o_uart_gnt(uart_gnt), .o_uart_rvalid(uart_rvalid), .o_uart_rdata(uart_rdata),
    .i_uart_lock(uart_lock), .o_locked(locked),
    .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata),
    .i_ram_rdata(ram_rdata)
  );

  // Environment RAM: synchronous single port, read data valid the cycle after the strobe.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr] = ram_wdata;
      else        ram_rdata <= ram[ram_addr];
    end
  end

  // Behavioural model: mode 0 shared, 1 locked, 2 release.
  int            m_mode, m_starve;
  bit            m_known;
  bit            m_pend_c, m_pend_u;
  logic [DW-1:0] m_pdata_c, m_pdata_u, m_hold_c, m_hold_u;
  logic [DW-1:0] m_mem [0:(1<<AW)-1];
  bit            e_c, e_u;

  int checks = 0;
  int errors = 0;

  logic          s_cpu_gnt, s_uart_gnt, s_cpu_stall, s_cpu_rvalid, s_uart_rvalid, s_locked, s_ram_en;
  logic [DW-1:0] s_cpu_rdata, s_uart_rdata;
  logic [9:0]    seq;

  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 'h012) return 32'hDEADBEEF;
    return (DW'(a) * 32'h9E3779B9) ^ 32'h0F0F1234;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle();
    logic          ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    e_c = 1'b0;
    e_u = 1'b0;
    if (rst_n) begin
      if (m_mode == 0) begin
        if (cpu_req && uart_req) begin
          if (m_starve >= SMAX) e_u = 1'b1;
          else                  e_c = 1'b1;
        end else begin
          e_c = cpu_req;
          e_u = uart_req;
        end
      end else if (m_mode == 1) begin
        e_u = uart_req;
      end
    end
    ew = e_c ? cpu_we   : (e_u ? uart_we   : 1'b0);
    ea = e_c ? cpu_addr : (e_u ? uart_addr : '0);
    ed = e_c ? cpu_wdata : (e_u ? uart_wdata : '0);
    s_cpu_gnt = cpu_gnt;       s_uart_gnt = uart_gnt;   s_cpu_stall = cpu_stall;
    s_cpu_rvalid = cpu_rvalid; s_uart_rvalid = uart_rvalid;
    s_cpu_rdata = cpu_rdata;   s_uart_rdata = uart_rdata;
    s_locked = locked;         s_ram_en = ram_en;
    chk("cpu_gnt", cpu_gnt, e_c);
    chk("uart_gnt", uart_gnt, e_u);
    chk("cpu_stall", cpu_stall, cpu_req & ~e_c);
    chk("ram_en", ram_en, e_c | e_u);
    chk("ram_we", ram_we, ew);
    chk("ram_addr", ram_addr, ea);
    chk("ram_wdata", ram_wdata, ed);
    if (m_known) begin
      chk("cpu_rvalid", cpu_rvalid, rst_n & m_pend_c);
      chk("uart_rvalid", uart_rvalid, rst_n & m_pend_u);
      chk("cpu_rdata", cpu_rdata, (rst_n && m_pend_c) ? m_pdata_c : m_hold_c);
      chk("uart_rdata", uart_rdata, (rst_n && m_pend_u) ? m_pdata_u : m_hold_u);
      chk("locked", locked, m_mode == 1);
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_mode = 0; m_starve = 0; m_pend_c = 0; m_pend_u = 0;
      m_hold_c = '0; m_hold_u = '0; m_known = 1'b1;
    end else begin
      if (m_pend_c) m_hold_c = m_pdata_c;
      if (m_pend_u) m_hold_u = m_pdata_u;
      m_pend_c  = e_c && !cpu_we;
      m_pend_u  = e_u && !uart_we;
      m_pdata_c = m_mem[cpu_addr];
      m_pdata_u = m_mem[uart_addr];
      if (e_c && cpu_we)  m_mem[cpu_addr]  = cpu_wdata;
      if (e_u && uart_we) m_mem[uart_addr] = uart_wdata;
      if (e_u) m_starve = 0;
      else if (m_mode == 0 && e_c && uart_req && m_starve < SMAX) m_starve++;
      case (m_mode)
        0: if (uart_lock) m_mode = 1;
        1: if (!uart_lock) m_mode = 2;
        default: begin m_mode = 0; m_starve = 0; end
      endcase
    end
  endtask

  task automatic tick();
    #3;
    check_cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    m_known = 1'b0; m_mode = 0; m_starve = 0; m_pend_c = 0; m_pend_u = 0;
    m_hold_c = '0; m_hold_u = '0; m_pdata_c = '0; m_pdata_u = '0;
    for (int a = 0; a < (1 << AW); a++) begin
      ram[a]   = init_val(a);
      m_mem[a] = init_val(a);
    end
    rst_n = 1'b0; uart_lock = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    uart_req = 1'b1; uart_we = 1'b0; uart_addr = '0; uart_wdata = '0;

    // Reset with both requesting
    tick(); tick();
    chk("rst_ram_en", s_ram_en, 1'b0);
    chk("rst_cpu_gnt", s_cpu_gnt, 1'b0);
    chk("rst_uart_gnt", s_uart_gnt, 1'b0);
    chk("rst_cpu_rvalid", s_cpu_rvalid, 1'b0);
    chk("rst_uart_rvalid", s_uart_rvalid, 1'b0);
    chk("rst_cpu_rdata", s_cpu_rdata, 32'h0);
    chk("rst_uart_rdata", s_uart_rdata, 32'h0);
    chk("rst_locked", s_locked, 1'b0);
    rst_n = 1'b1; cpu_req = 1'b0; uart_req = 1'b0;
    tick();

    // Solo CPU read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'('h012);
    tick();
    chk("solo_gnt", s_cpu_gnt, 1'b1);
    cpu_req = 1'b0;
    tick();
    chk("solo_rvalid", s_cpu_rvalid, 1'b1);
    chk("solo_rdata", s_cpu_rdata, 32'hDEADBEEF);
    chk("solo_uart_rvalid", s_uart_rvalid, 1'b0);
    chk("solo_uart_rdata", s_uart_rdata, 32'h0);

    // Starvation guard: both requesting continuously
    seq = '0;
    cpu_req = 1'b1; uart_req = 1'b1; uart_we = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cpu_addr = AW'($urandom_range(0, 31));
      uart_addr = AW'($urandom_range(32, 63));
      uart_wdata = $urandom;
      tick();
      seq = {seq[8:0], s_uart_gnt};
    end
    chk("starve_seq", seq, 10'b0000100001);

    // Lock entry: the rising cycle is arbitrated normally
    uart_lock = 1'b1; uart_we = 1'b0; uart_addr = AW'(5);
    tick();
    chk("lock_rise_cpu_gnt", s_cpu_gnt, 1'b1);
    chk("lock_rise_locked", s_locked, 1'b0);
    for (int i = 0; i < 8; i++) begin
      uart_we = 1'b1; uart_addr = AW'('h200 + i); uart_wdata = 32'hA5000000 | DW'(i);
      tick();
      chk("lock_stall", s_cpu_stall, 1'b1);
      chk("lock_locked", s_locked, 1'b1);
      chk("lock_uart_gnt", s_uart_gnt, 1'b1);
    end
    uart_we = 1'b0; uart_addr = AW'('h203); uart_lock = 1'b0;
    tick();
    chk("lock_last_read_gnt", s_uart_gnt, 1'b1);

    // Release: no grants, lock toggling ignored, outstanding UART read lands
    uart_lock = 1'b1;
    tick();
    chk("rel_cpu_gnt", s_cpu_gnt, 1'b0);
    chk("rel_uart_gnt", s_uart_gnt, 1'b0);
    chk("rel_uart_rvalid", s_uart_rvalid, 1'b1);
    chk("rel_uart_rdata", s_uart_rdata, 32'hA5000003);
    chk("rel_locked", s_locked, 1'b0);
    uart_lock = 1'b0;
    tick();
    chk("post_rel_cpu_gnt", s_cpu_gnt, 1'b1);
    seq = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seq = {seq[8:0], s_uart_gnt};
    end
    chk("post_rel_starve", seq, 10'b0000000001);

    // Reset in the cycle after a CPU read grant
    uart_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'('h012);
    tick();
    chk("mid_gnt", s_cpu_gnt, 1'b1);
    cpu_req = 1'b0; rst_n = 1'b0;
    tick();
    chk("mid_rvalid_during", s_cpu_rvalid, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("mid_rvalid_after", s_cpu_rvalid, 1'b0);
    tick();
    chk("mid_rvalid_later", s_cpu_rvalid, 1'b0);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      rst_n      = ($urandom_range(0, 99) != 0);
      cpu_req    = ($urandom_range(0, 9) < 7);
      uart_req   = ($urandom_range(0, 9) < 6);
      cpu_we     = $urandom_range(0, 1) != 0;
      uart_we    = $urandom_range(0, 1) != 0;
      cpu_addr   = AW'($urandom_range(0, 31));
      uart_addr  = AW'($urandom_range(0, 31));
      cpu_wdata  = $urandom;
      uart_wdata = $urandom;
      if ($urandom_range(0, 19) == 0) uart_lock = ~uart_lock;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous data RAM between the CPU MEM-stage data port and the UART loader port. CPU has fixed priority with a bounded-starvation guard for UART; UART can also take an exclusive lock for bulk program and data loading. The block sits between the pipeline's MEM stage and the data RAM inside the bus. Its `cpu_stall` output feeds the pipeline's stall logic.

## Interface
Parameters:
- `ADDR_W`, default 10: RAM word-address width.
- `DATA_W`, default 32: data width.
- `STARVE_MAX`, default 4, must be ≥1: number of contested cycles CPU may win in a row before UART is forced through.

Ports:
- `clk`  in  1  sole clock; everything is on its rising edge.
- `reset`  in  1  one clock; reset is synchronous and active-low.
- `cpu_req`  in  1  CPU access request; held with its payload until granted.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  ADDR_W  word address.
- `cpu_wdata`  in  DATA_W  write data.
- `cpu_gnt`  out  1  combinational; the access is performed this cycle.
- `cpu_stall`  out  1  `cpu_req & ~cpu_gnt`.
- `cpu_rvalid`  out  1  read data valid, registered.
- `cpu_rdata`  out  DATA_W  read data.
- `uart_req`, `uart_we`, `uart_addr`, `uart_wdata`, `uart_gnt`, `uart_rvalid`, `uart_rdata`: same semantics as the CPU ports, for the UART requester.
- `uart_lock`  in  1  requests exclusive ownership for UART.
- `locked`  out  1  high while in LOCKED.
- `ram_en`  out  1  RAM access strobe.
- `ram_we`  out  1  RAM write enable.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_wdata`  out  DATA_W  RAM write data.
- `ram_rdata`  in  DATA_W  RAM read data, valid the cycle after a read strobe.

## Operation
States:
- SHARED: normal arbitration.
  - Only one requester active: it is granted.
  - Both requesting (contested cycle): CPU is granted unless `starve_cnt == STARVE_MAX`; in that case UART is granted.
  - `starve_cnt` increments on each contested cycle CPU wins.
  - `starve_cnt` clears on any UART grant.
- SHARED → LOCKED: when `uart_lock` is sampled high at a clock edge. The cycle in which `uart_lock` first rises is still arbitrated normally.
- LOCKED:
  - `uart_gnt = uart_req`; `cpu_gnt = 0`, so the CPU stalls for the whole lock.
  - `locked = 1`.
- LOCKED → RELEASE: when `uart_lock` is sampled low.
- RELEASE: exactly one turnaround cycle with no grants. The outstanding UART read completes during it.
- RELEASE → SHARED: unconditional; `starve_cnt` clears.

RAM drive:
- `ram_en = cpu_gnt | uart_gnt`.
- `ram_we`, `ram_addr` and `ram_wdata` are muxed from the granted requester.
- When nothing is granted they are 0.
- At most one grant is asserted per cycle.

Read return:
- A granted read registers a one-bit owner tag plus a pending flag.
- Next cycle, the owner's `*_rvalid = 1` and its `*_rdata = ram_rdata`.
- The non-owner's `rdata` holds its previous value.
- A granted write produces no `rvalid`.

Width rules:
- `starve_cnt` is `$clog2(STARVE_MAX+1)` bits.
- `starve_cnt` saturates at `STARVE_MAX`.

## Timing
- Reset (`reset == 0` at an edge) sets:
  - state = SHARED, `starve_cnt = 0`, pending flag = 0;
  - `cpu_rvalid = uart_rvalid = 0`;
  - `cpu_rdata = uart_rdata = 0`;
  - `locked = 0`.
- While `reset == 0`, all grants and `ram_en` are forced to 0.
- Grant latency is 0 cycles (combinational from registered state plus current requests).
- Read latency is 1 cycle from grant to `rvalid`. Back-to-back reads are supported at one per cycle.
- Reset asserted in the cycle after a read grant: the `rvalid` is suppressed, and it is not delivered after reset.
- `uart_lock` toggling while in RELEASE: ignored. It is re-sampled once the state is SHARED.
- `uart_lock` high with CPU stalled mid-request: CPU keeps `cpu_req` high. It is granted in the first SHARED cycle after RELEASE, with priority rules applied.
- UART requesting without a lock in LOCKED-adjacent cycles: RELEASE grants nothing, even to UART.

## Structure
- Shared package holds:
  - state encodings ARB_SHARED = 2'd0, ARB_LOCKED = 2'd1, ARB_RELEASE = 2'd2;
  - owner tag constants OWN_CPU = 1'b0, OWN_UART = 1'b1.
- Single module, no sub-module. The starvation counter is small and stays inline.

## Test plan
- Reset: hold `reset = 0` for 2 cycles with both requests high → all grants, `ram_en`, `rvalid` and `locked` read 0; `rdata = 0`.
- Solo read: CPU reads address 0x012, RAM returns 0xDEADBEEF → `cpu_gnt` is high that same cycle; next cycle `cpu_rvalid = 1` and `cpu_rdata = 0xDEADBEEF`; UART outputs stay unchanged.
- Starvation guard: both request continuously with `STARVE_MAX = 4` → grant sequence C, C, C, C, U, C, C, C, C, U.
- Lock entry: CPU and UART both requesting, `uart_lock` rises → that cycle is normal arbitration; `locked = 1` from the next cycle; UART then writes 8 consecutive words with `cpu_stall = 1` throughout.
- Release: drop `uart_lock` after a UART read → one RELEASE cycle with no grants in which `uart_rvalid` fires; then CPU is granted and `starve_cnt = 0`.
- Reset mid-read: CPU read granted, then `reset = 0` the next cycle → `cpu_rvalid` stays 0 before, during and after reset.
